// File: rtl/frame_sequencer_pkg.sv
// Shared types and defaults for the frame sequencer: FSM state encoding,
// pipeline mode codes, data word size and default frame geometry.
package frame_sequencer_pkg;

    localparam int WORD_SIZE        = 8;
    localparam int DEF_FRAME_WIDTH  = 640;
    localparam int DEF_FRAME_HEIGHT = 480;
    localparam int DEF_FLUSH_LEN    = 2 * DEF_FRAME_WIDTH + 4;
    localparam int DEF_CNT_WIDTH    = 11;
    localparam int DEF_TIMEOUT      = 4096;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ACTIVE = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } seq_state_e;

    typedef enum logic [WORD_SIZE-1:0] {
        MODE_PASS   = 8'd0,
        MODE_GRAY   = 8'd1,
        MODE_SOBEL  = 8'd2,
        MODE_THRESH = 8'd3,
        MODE_CC     = 8'd4,
        MODE_COLOR  = 8'd5
    } mode_e;

    // Bits needed to hold values 0 .. n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/handshake bundle between the pixel source / host and the sequencer.
// in_valid/in_ready: a pixel moves in every cycle both are high; in_ready is
// only high in ACTIVE. cfg_wr is held until the one-cycle cfg_ack, then dropped.
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 cfg_wr;
    logic [WORD_SIZE-1:0] cfg_mode;
    logic [WORD_SIZE-1:0] cfg_threshold;
    logic                 cfg_ack;
    logic                 pipe_en;
    logic                 pipe_hsync;
    logic                 pipe_vsync;
    logic                 pad;
    logic [WORD_SIZE-1:0] mode;
    logic [WORD_SIZE-1:0] threshold;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          frame_count;
    logic                 timeout_err;
    seq_state_e           dbg_state;

    modport master (
        output start, in_valid, cfg_wr, cfg_mode, cfg_threshold,
        input  in_ready, cfg_ack, pipe_en, pipe_hsync, pipe_vsync, pad,
               mode, threshold, busy, frame_done, frame_count, timeout_err,
               dbg_state
    );

    modport slave (
        input  start, in_valid, cfg_wr, cfg_mode, cfg_threshold,
        output in_ready, cfg_ack, pipe_en, pipe_hsync, pipe_vsync, pad,
               mode, threshold, busy, frame_done, frame_count, timeout_err,
               dbg_state
    );

endinterface

// File: rtl/frame_sequencer_cfg_shadow.sv
// Shadow/active configuration pair: host writes land in the shadow with a
// one-cycle ack; the active copy only changes when the sequencer starts a frame.
module frame_sequencer_cfg_shadow
    import frame_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_wr_i,
    input  logic [WORD_SIZE-1:0] cfg_mode_i,
    input  logic [WORD_SIZE-1:0] cfg_threshold_i,
    input  logic                 copy_i,
    output logic                 cfg_ack_o,
    output logic [WORD_SIZE-1:0] mode_o,
    output logic [WORD_SIZE-1:0] threshold_o
);

    logic                 ack_q;
    logic [WORD_SIZE-1:0] shadow_mode_q;
    logic [WORD_SIZE-1:0] shadow_thr_q;
    logic [WORD_SIZE-1:0] mode_q;
    logic [WORD_SIZE-1:0] thr_q;
    logic                 accept;

    // A write still held high during its own ack cycle must not re-trigger.
    assign accept = cfg_wr_i && !ack_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q         <= 1'b0;
            shadow_mode_q <= MODE_PASS;
            shadow_thr_q  <= '0;
            mode_q        <= MODE_PASS;
            thr_q         <= '0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                shadow_mode_q <= cfg_mode_i;
                shadow_thr_q  <= cfg_threshold_i;
            end
            // Nonblocking copy reads the shadow before a same-cycle write.
            if (copy_i) begin
                mode_q <= shadow_mode_q;
                thr_q  <= shadow_thr_q;
            end
        end
    end

    assign cfg_ack_o   = ack_q;
    assign mode_o      = mode_q;
    assign threshold_o = thr_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks IDLE -> START -> ACTIVE -> FLUSH -> DONE per frame,
// drives pipeline enable/sync/pad strobes. Optional stall watchdog: FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int FLUSH_LEN    = DEF_FLUSH_LEN,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input logic              clk,
    input logic              reset_n,
    frame_sequencer_if.slave bus
);

    localparam int FLUSH_W = cnt_bits(FLUSH_LEN);
    localparam logic [CNT_WIDTH-1:0] X_LAST     = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST     = CNT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);

    if (FRAME_WIDTH < 1 || FRAME_HEIGHT < 1 || FLUSH_LEN < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("frame_sequencer: geometry, flush and timeout parameters must be positive");
    end

    seq_state_e           state_q;
    logic [CNT_WIDTH-1:0] x_q;
    logic [CNT_WIDTH-1:0] y_q;
    logic [FLUSH_W-1:0]   flush_q;
    logic [15:0]          frame_count_q;
    logic                 xfer;
    logic                 x_last;
    logic                 start_copy;

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam int STALL_W = cnt_bits(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    logic [STALL_W-1:0] stall_q;
    logic               timeout_q;
`endif

    assign xfer       = (state_q == S_ACTIVE) && bus.in_valid;
    assign x_last     = (x_q == X_LAST);
    assign start_copy = (state_q == S_START);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            flush_q       <= '0;
            frame_count_q <= '0;
`ifdef FRAME_SEQ_WATCHDOG_EN
            stall_q       <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) state_q <= S_START;
                S_START: begin
                    x_q     <= '0;
                    y_q     <= '0;
`ifdef FRAME_SEQ_WATCHDOG_EN
                    stall_q <= '0;
`endif
                    state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (xfer) begin
                        if (x_last) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                            if (y_q == Y_LAST) begin
                                flush_q <= FLUSH_LAST;
                                state_q <= S_FLUSH;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
`ifdef FRAME_SEQ_WATCHDOG_EN
                    // A stalled source truncates the frame rather than hanging the pipe.
                    if (bus.in_valid) begin
                        stall_q <= '0;
                    end else if (stall_q == STALL_LAST) begin
                        stall_q   <= '0;
                        timeout_q <= 1'b1;
                        flush_q   <= FLUSH_LAST;
                        state_q   <= S_FLUSH;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
                S_FLUSH: begin
                    // x keeps running so row-end strobes continue through the drain.
                    x_q <= x_last ? '0 : x_q + 1'b1;
                    if (flush_q == '0) state_q <= S_DONE;
                    else               flush_q <= flush_q - 1'b1;
                end
                S_DONE: begin
                    frame_count_q <= frame_count_q + 1'b1;
                    state_q       <= bus.start ? S_START : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    frame_sequencer_cfg_shadow u_cfg (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_wr_i        (bus.cfg_wr),
        .cfg_mode_i      (bus.cfg_mode),
        .cfg_threshold_i (bus.cfg_threshold),
        .copy_i          (start_copy),
        .cfg_ack_o       (bus.cfg_ack),
        .mode_o          (bus.mode),
        .threshold_o     (bus.threshold)
    );

    // Strobes decode the registered state; only pipe_en/hsync in ACTIVE see in_valid.
    assign bus.in_ready    = (state_q == S_ACTIVE);
    assign bus.pipe_en     = xfer || (state_q == S_FLUSH);
    assign bus.pipe_hsync  = (xfer || (state_q == S_FLUSH)) && x_last;
    assign bus.pipe_vsync  = (state_q == S_START);
    assign bus.pad         = (state_q == S_FLUSH);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = (state_q == S_DONE);
    assign bus.frame_count = frame_count_q;
    assign bus.dbg_state   = state_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
